// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive slave with an MSB-first response shifter.
// sclk, cs_n and mosi are oversampled on clk through a synchronizer chain;
// received words are handed to the consumer through a valid/ready register.
module spi_slave_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    cs_n,
    input  logic                    mosi,
    output logic                    miso,
    input  logic [DATA_W-1:0]       tx_data,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    overrun,
    output logic                    frame_err,
    output logic [$clog2(DATA_W):0] bit_count
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] flush_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    state_t              state_q,     state_d;
    logic [DATA_W-1:0]   tx_q,        tx_d;
    logic [DATA_W-1:0]   rx_shift_q,  rx_shift_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [DATA_W-1:0]   rx_data_q,   rx_data_d;
    logic                rx_valid_q,  rx_valid_d;
    logic                overrun_q,   overrun_d;
    logic                frame_err_q, frame_err_d;
    logic                armed_q,     armed_d;

    // Synchronizer chains plus the extra copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_shift_q  <= '0;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_shift_q  <= rx_shift_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
        end
    end

    // Next-state, shifting and handshake logic.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_shift_d  = rx_shift_q;
        cnt_d       = cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        // The synchronizer restarts at the idle level after reset, so a low
        // cs_n pin would look like a fresh falling edge; only accept frames
        // once the flushed chain has shown cs_n genuinely high.
        armed_d     = armed_q | (flush_q[SYNC_STAGES-1] & cs_s);

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d    = SHIFT;
                    tx_d       = tx_data;
                    rx_shift_d = '0;
                    cnt_d      = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    frame_err_d = (cnt_q != '0);
                    cnt_d      = '0;
                    rx_shift_d = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            state_d = HOLD;
                        end
                    end
                    // A falling edge with no bits counted follows a completed
                    // word: it presents the next word's MSB instead of shifting.
                    if (sclk_fall) begin
                        if (cnt_q == '0) begin
                            tx_d = tx_data;
                        end else begin
                            tx_d = {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (!rx_valid_q || rx_ready) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                if (sclk_fall) begin
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
                state_d = cs_rise ? IDLE : SHIFT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign miso      = (state_q != IDLE) & tx_q[DATA_W-1];
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table of single frames, hand-written
// corner sequences and randomized multi-word frames against a word-queue model.
module tb_spi_slave_rx;

    localparam int DW   = 16;
    localparam int S    = 2;
    localparam int HALF = 8;

    logic          clk;
    logic          rst;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          overrun;
    logic          frame_err;
    logic [4:0]    bit_count;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0;
    int ovr_cnt = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];

    spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
        .frame_err(frame_err), .bit_count(bit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            fe_cnt  += int'(frame_err);
            ovr_cnt += int'(overrun);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master drives the top nbits of mo, sampling miso on each sclk rise.
    task automatic send_bits(input logic [DW-1:0] mo, input int nbits, output logic [DW-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[DW-1-i];
            wait_clk(HALF);
            mi[DW-1-i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic do_frame(input logic [DW-1:0] mo, input logic [DW-1:0] tx, input int nbits,
                            output logic [DW-1:0] mi);
        tx_data = tx;
        cs_n = 1'b0;
        wait_clk(HALF);
        send_bits(mo, nbits, mi);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("consume_clears_valid", 32'(rx_valid), 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] mo;
        logic [DW-1:0] tx;
        int            nbits;
        logic          exp_valid;
        logic [DW-1:0] exp_rx;
        logic [DW-1:0] exp_mi;
        int            exp_fe;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [DW-1:0] mi;
        logic [DW-1:0] mo;
        logic [DW-1:0] tx;
        int fe0;
        int ov0;
        int lat;
        int efe;

        tbl[0] = '{16'hA5C3, 16'h1234, 16, 1'b1, 16'hA5C3, 16'h1234, 0};
        tbl[1] = '{16'hBEEF, 16'h0000,  7, 1'b0, 16'hA5C3, 16'h0000, 1};
        tbl[2] = '{16'hBEEF, 16'hFFFF, 16, 1'b1, 16'hBEEF, 16'hFFFF, 0};
        tbl[3] = '{16'h0000, 16'h8001, 16, 1'b1, 16'h0000, 16'h8001, 0};
        tbl[4] = '{16'hFFFF, 16'h5AA5,  1, 1'b0, 16'h0000, 16'h0000, 1};
        tbl[5] = '{16'h8001, 16'hC3C3, 16, 1'b1, 16'h8001, 16'hC3C3, 0};
        tbl[6] = '{16'h1357, 16'h2468, 15, 1'b0, 16'h8001, 16'h2468, 1};
        tbl[7] = '{16'hFFFF, 16'h0001, 16, 1'b1, 16'hFFFF, 16'h0001, 0};

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = '0; rx_ready = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(1);

        // Reset values.
        chk("rst_rx_valid",  32'(rx_valid),  32'd0);
        chk("rst_rx_data",   32'(rx_data),   32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        chk("rst_miso",      32'(miso),      32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        wait_clk(10);

        // sclk activity with cs_n high is ignored.
        tx_data = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
            chk("idle_bit_count", 32'(bit_count), 32'd0);
            chk("idle_miso", 32'(miso), 32'd0);
        end
        chk("idle_rx_valid", 32'(rx_valid), 32'd0);

        // Table of single frames, consumer not ready during the frame.
        for (int i = 0; i < 8; i++) begin
            fe0 = fe_cnt; ov0 = ovr_cnt;
            do_frame(tbl[i].mo, tbl[i].tx, tbl[i].nbits, mi);
            chk($sformatf("tbl%0d_valid", i), 32'(rx_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_rx_data", i), 32'(rx_data), 32'(tbl[i].exp_rx));
            chk($sformatf("tbl%0d_miso_word", i), 32'(mi), 32'(tbl[i].exp_mi));
            chk($sformatf("tbl%0d_frame_err", i), 32'(fe_cnt - fe0), 32'(tbl[i].exp_fe));
            chk($sformatf("tbl%0d_overrun", i), 32'(ovr_cnt - ov0), 32'd0);
            chk($sformatf("tbl%0d_bit_count", i), 32'(bit_count), 32'd0);
            chk($sformatf("tbl%0d_idle_miso", i), 32'(miso), 32'd0);
            if (rx_valid) consume();
        end

        // Latency from the clk edge first sampling the final sclk high.
        tx_data = '0;
        cs_n = 1'b0;
        wait_clk(HALF);
        send_bits(16'h3C5A, 15, mi);
        mosi = 1'b0;
        wait_clk(HALF);
        sclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rx_valid && lat == 0) lat = k;
        end
        sclk = 1'b0;
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        chk("latency_cycles", 32'(lat), 32'(S + 2));
        chk("latency_rx_data", 32'(rx_data), 32'h3C5A);
        consume();

        // Back-to-back words with consumer ready.
        fe0 = fe_cnt; ov0 = ovr_cnt;
        got_q.delete();
        rx_ready = 1'b1;
        tx_data = 16'hC001;
        cs_n = 1'b0;
        wait_clk(HALF);
        send_bits(16'h0001, 16, mi);
        chk("b2b_miso_w0", 32'(mi), 32'hC001);
        chk("b2b_bit_count_wrap", 32'(bit_count), 32'd0);
        tx_data = 16'h7E57;
        send_bits(16'hFFFF, 16, mi);
        chk("b2b_miso_w1", 32'(mi), 32'h7E57);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        rx_ready = 1'b0;
        chk("b2b_handshakes", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) begin
            chk("b2b_word0", 32'(got_q[0]), 32'h0001);
            chk("b2b_word1", 32'(got_q[1]), 32'hFFFF);
        end
        chk("b2b_errors", 32'((fe_cnt - fe0) + (ovr_cnt - ov0)), 32'd0);

        // Overrun: consumer stalled across two words.
        ov0 = ovr_cnt;
        tx_data = '0;
        cs_n = 1'b0;
        wait_clk(HALF);
        send_bits(16'h1111, 16, mi);
        send_bits(16'h2222, 16, mi);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        chk("ovr_rx_data", 32'(rx_data), 32'h1111);
        chk("ovr_rx_valid", 32'(rx_valid), 32'd1);
        chk("ovr_pulses", 32'(ovr_cnt - ov0), 32'd1);
        consume();

        // Reset mid-frame with a word still pending.
        do_frame(16'h4242, 16'h0000, 16, mi);
        chk("pre_rst_valid", 32'(rx_valid), 32'd1);
        fe0 = fe_cnt;
        cs_n = 1'b0;
        wait_clk(HALF);
        send_bits(16'hF0F0, 9, mi);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        chk("mid_rst_rx_valid",  32'(rx_valid),  32'd0);
        chk("mid_rst_rx_data",   32'(rx_data),   32'd0);
        chk("mid_rst_bit_count", 32'(bit_count), 32'd0);
        chk("mid_rst_miso",      32'(miso),      32'd0);
        send_bits(16'hFFFF, 4, mi);
        chk("after_rst_ignored_bits", 32'(bit_count), 32'd0);
        chk("after_rst_miso", 32'(miso), 32'd0);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        chk("after_rst_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
        do_frame(16'h8001, 16'h0000, 16, mi);
        chk("after_rst_rx_data", 32'(rx_data), 32'h8001);
        chk("after_rst_rx_valid", 32'(rx_valid), 32'd1);
        consume();

        // Randomized frames against a word-queue model, consumer always ready.
        got_q.delete();
        exp_q.delete();
        fe0 = fe_cnt; ov0 = ovr_cnt;
        efe = 0;
        rx_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int nw;
            nw = int'($urandom_range(1, 3));
            tx = 16'($urandom);
            tx_data = tx;
            cs_n = 1'b0;
            wait_clk(HALF);
            for (int w = 0; w < nw; w++) begin
                if (w != 0) begin
                    tx = 16'($urandom);
                    tx_data = tx;
                end
                mo = 16'($urandom);
                send_bits(mo, 16, mi);
                exp_q.push_back(mo);
                chk($sformatf("rnd%0d_w%0d_miso", f, w), 32'(mi), 32'(tx));
            end
            if ($urandom_range(0, 2) == 0) begin
                send_bits(16'($urandom), int'($urandom_range(1, 15)), mi);
                efe++;
            end
            wait_clk(HALF);
            cs_n = 1'b1;
            wait_clk(2 * HALF);
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                chk($sformatf("rnd%0d_word", f), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
            end
            chk($sformatf("rnd%0d_pending_exp", f), 32'(exp_q.size()), 32'd0);
            chk($sformatf("rnd%0d_extra_got", f), 32'(got_q.size()), 32'd0);
        end
        rx_ready = 1'b0;
        chk("rnd_frame_err_count", 32'(fe_cnt - fe0), 32'(efe));
        chk("rnd_overrun_count", 32'(ovr_cnt - ov0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
